// File: rtl/inst_encoder.sv
// Turns a symbolic command (op, mode, operand) into the CPU's 16-bit instruction word
// and streams it MSB-first as one or two bytes over a valid/ready byte interface.
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [2:0]  cmd_mode,
    input  logic [10:0] cmd_arg,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        err,
    output logic [15:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic [15:0] enc_word;
    logic        enc_illegal;
    logic        shift_dir;

    // Command encoder: SHL/SHR differ only in op[0], which doubles as the shift direction bit.
    always_comb begin
        enc_word    = 16'h0000;
        enc_illegal = 1'b0;
        shift_dir   = cmd_op[0];
        if (!cmd_op[4]) begin
            enc_word    = {4'h0, cmd_op[3:0], 8'h00};
            enc_illegal = (cmd_op[3:0] == 4'hB);
        end else begin
            case (cmd_op[3:0])
                4'h0: enc_word = 16'h4400;
                4'h1: enc_word = {5'b10000, cmd_mode, cmd_arg[7:0]};
                4'h2: begin
                    enc_word    = {5'b10010, cmd_mode, cmd_arg[7:0]};
                    enc_illegal = !cmd_mode[2];
                end
                4'h3: enc_word = {5'b10001, cmd_mode, cmd_arg[7:0]};
                4'h4: enc_word = {5'b10011, cmd_mode, cmd_arg[7:0]};
                4'h5: enc_word = {5'b10100, cmd_mode, cmd_arg[7:0]};
                4'h6: enc_word = {5'b10101, cmd_mode, cmd_arg[7:0]};
                4'h7: enc_word = {5'b10110, cmd_mode, cmd_arg[7:0]};
                4'h8, 4'h9: begin
                    // Odd modes (001, 011, 101, 111) have no shift encoding.
                    enc_illegal = cmd_mode[0];
                    if (cmd_mode[2]) begin
                        enc_word = {5'b10111, cmd_mode, cmd_arg[7:1], shift_dir};
                    end else begin
                        enc_word = {5'b10111, 1'b0, cmd_mode[1], shift_dir, cmd_arg[7:0]};
                    end
                end
                4'hA: enc_word = {5'b11000, cmd_arg[10:0]};
                4'hB: enc_word = {5'b11010, cmd_arg[10:0]};
                4'hC: begin
                    enc_word    = {5'b11110, 8'h00, cmd_arg[2:0]};
                    enc_illegal = (cmd_arg[2:0] > 3'd5);
                end
                default: enc_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    word_d = enc_word;
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = EMIT_HI;
                    end
                end
            end
            EMIT_HI: begin
                // Zero-arg instructions have bit 15 clear and fit in the high byte alone.
                if (byte_ready) begin
                    if (!word_q[15]) begin
                        state_d = IDLE;
                        count_d = count_q + 16'd1;
                    end else begin
                        state_d = EMIT_LO;
                    end
                end
            end
            EMIT_LO: begin
                if (byte_ready) begin
                    state_d = IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 16'h0000;
            err_q   <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        case (state_q)
            EMIT_HI: begin
                byte_valid = 1'b1;
                byte_data  = word_q[15:8];
                byte_last  = !word_q[15];
            end
            EMIT_LO: begin
                byte_valid = 1'b1;
                byte_data  = word_q[7:0];
                byte_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err        = err_q;
    assign inst_count = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed instruction bytes, error pulses,
// backpressure hold and reset mid-instruction.
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_mode;
    logic [10:0] cmd_arg;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        err;
    logic [15:0] inst_count;

    int errors = 0;
    int checks = 0;

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mode   (cmd_mode),
        .cmd_arg    (cmd_arg),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .err        (err),
        .inst_count (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] op, input logic [2:0] mode, input logic [10:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = mode;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] data, input logic last);
        check_output({tag, "_valid"}, {31'd0, byte_valid}, 32'd1);
        check_output({tag, "_data"}, {24'd0, byte_data}, {24'd0, data});
        check_output({tag, "_last"}, {31'd0, byte_last}, {31'd0, last});
        byte_ready = 1'b1;
        step();
        byte_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 5'd0;
        cmd_mode   = 3'd0;
        cmd_arg    = 11'd0;
        byte_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check_output("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_output("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check_output("rst_byte_data", {24'd0, byte_data}, 32'd0);
        check_output("rst_byte_last", {31'd0, byte_last}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        check_output("rst_count", {16'd0, inst_count}, 32'd0);

        // ADD mode 000 arg 0x12
        apply_stimulus(5'h13, 3'b000, 11'h012);
        check_output("add_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        expect_byte("add_hi", 8'h88, 1'b0);
        check_output("add_count_mid", {16'd0, inst_count}, 32'd0);
        expect_byte("add_lo", 8'h12, 1'b1);
        check_output("add_count", {16'd0, inst_count}, 32'd1);
        check_output("add_idle_valid", {31'd0, byte_valid}, 32'd0);

        apply_stimulus(5'h00, 3'b000, 11'h000);
        expect_byte("nop", 8'h00, 1'b1);
        check_output("nop_count", {16'd0, inst_count}, 32'd2);
        apply_stimulus(5'h10, 3'b000, 11'h000);
        expect_byte("load_ind", 8'h44, 1'b1);
        check_output("load_ind_count", {16'd0, inst_count}, 32'd3);
        apply_stimulus(5'h07, 3'b000, 11'h000);
        expect_byte("zero_arg7", 8'h07, 1'b1);

        apply_stimulus(5'h1A, 3'b000, 11'h7FF);
        expect_byte("branch_hi", 8'hC7, 1'b0);
        expect_byte("branch_lo", 8'hFF, 1'b1);
        apply_stimulus(5'h19, 3'b110, 11'h006);
        expect_byte("shr_hi", 8'hBE, 1'b0);
        expect_byte("shr_lo", 8'h07, 1'b1);
        apply_stimulus(5'h18, 3'b010, 11'h0A5);
        expect_byte("shl_hi", 8'hBA, 1'b0);
        expect_byte("shl_lo", 8'hA5, 1'b1);
        apply_stimulus(5'h1C, 3'b000, 11'h005);
        expect_byte("if_hi", 8'hF0, 1'b0);
        expect_byte("if_lo", 8'h05, 1'b1);
        apply_stimulus(5'h1B, 3'b000, 11'h400);
        expect_byte("call_hi", 8'hD4, 1'b0);
        expect_byte("call_lo", 8'h00, 1'b1);
        apply_stimulus(5'h17, 3'b011, 11'h03C);
        expect_byte("xor_hi", 8'hB3, 1'b0);
        expect_byte("xor_lo", 8'h3C, 1'b1);
        apply_stimulus(5'h12, 3'b100, 11'h001);
        expect_byte("store_hi", 8'h94, 1'b0);
        expect_byte("store_lo", 8'h01, 1'b1);
        check_output("legal_count", {16'd0, inst_count}, 32'd11);

        // Illegal commands: err pulse, no bytes, no count
        apply_stimulus(5'h12, 3'b000, 11'h055);
        check_output("store_m0_err", {31'd0, err}, 32'd1);
        check_output("store_m0_valid", {31'd0, byte_valid}, 32'd0);
        check_output("store_m0_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        check_output("store_m0_err_clear", {31'd0, err}, 32'd0);
        apply_stimulus(5'h0B, 3'b000, 11'h000);
        check_output("op0b_err", {31'd0, err}, 32'd1);
        apply_stimulus(5'h1D, 3'b000, 11'h000);
        check_output("op1d_err", {31'd0, err}, 32'd1);
        apply_stimulus(5'h18, 3'b101, 11'h000);
        check_output("shl_m5_err", {31'd0, err}, 32'd1);
        apply_stimulus(5'h19, 3'b001, 11'h000);
        check_output("shr_m1_err", {31'd0, err}, 32'd1);
        apply_stimulus(5'h1C, 3'b000, 11'h006);
        check_output("if_c6_err", {31'd0, err}, 32'd1);
        check_output("illegal_valid", {31'd0, byte_valid}, 32'd0);
        step();
        check_output("illegal_err_clear", {31'd0, err}, 32'd0);
        check_output("illegal_count", {16'd0, inst_count}, 32'd11);

        // Backpressure: byte held, new command ignored
        apply_stimulus(5'h13, 3'b000, 11'h055);
        cmd_valid = 1'b1;
        cmd_op    = 5'h00;
        for (int i = 0; i < 5; i++) begin
            check_output("hold_data", {24'd0, byte_data}, 32'h88);
            check_output("hold_last", {31'd0, byte_last}, 32'd0);
            check_output("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        expect_byte("hold_hi", 8'h88, 1'b0);
        expect_byte("hold_lo", 8'h55, 1'b1);
        check_output("hold_idle_valid", {31'd0, byte_valid}, 32'd0);
        check_output("hold_count", {16'd0, inst_count}, 32'd12);

        // Reset while in EMIT_LO
        apply_stimulus(5'h13, 3'b000, 11'h012);
        expect_byte("rst_mid_hi", 8'h88, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rst_mid_valid", {31'd0, byte_valid}, 32'd0);
        check_output("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        check_output("rst_mid_count", {16'd0, inst_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
